// File: rtl/result_stream_reader_pkg.sv
// Shared types and sizing for the result read-back path: memory word layout,
// lane indexing and the reader FSM state encoding.
package result_stream_reader_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    // Lane 0 sits in the low byte, matching the datapath shift-register fill order
    typedef logic [LANES-1:0][DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        SEND   = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/result_stream_reader_if.sv
// Bundle of the request, memory-read and byte-stream signals of the reader.
// slave is the reader itself; master is the controller/memory/consumer side.
interface result_stream_reader_if;
    import result_stream_reader_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_data_in;
    logic [DATA_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, word_count, mem_data_in, byte_ready,
        input  mem_rd_en, mem_addr, byte_out, byte_valid, busy, done
    );

    modport slave (
        input  start, base_addr, word_count, mem_data_in, byte_ready,
        output mem_rd_en, mem_addr, byte_out, byte_valid, busy, done
    );

endinterface

// File: rtl/result_stream_reader_lane_serializer.sv
// Holds one fetched memory word and presents its lanes one at a time,
// lane 0 first, advancing only when told to.
module result_stream_reader_lane_serializer
    import result_stream_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  word_t             word_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] byte_o,
    output logic              last_lane_o
);

    word_t             word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;

    // Next word/lane: a load restarts at lane 0, an advance steps one lane
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (load_i) begin
            word_d = word_i;
            lane_d = '0;
        end else if (advance_i) begin
            lane_d = lane_q + LANE_W'(1);
        end else begin
            word_d = word_q;
            lane_d = lane_q;
        end
    end

    // Word and lane registers
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign byte_o      = word_q[lane_q];
    assign last_lane_o = (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/result_stream_reader.sv
// Reads packed 4-lane result words back from memory starting at a base address
// and streams their bytes out over a valid/ready handshake, one word at a time.
module result_stream_reader
    import result_stream_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    result_stream_reader_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              byte_valid_q, byte_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              load_s;
    logic              advance_s;
    logic              xfer_s;
    logic              last_lane_s;
    logic [DATA_W-1:0] byte_s;

    assign xfer_s = byte_valid_q && bus.byte_ready;

    // Next state, counters and the values every registered output takes next cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_count;
                    state_d     = (bus.word_count == '0) ? FINISH : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                load_s      = 1'b1;
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - ADDR_W'(1);
                state_d     = SEND;
            end
            SEND: begin
                if (xfer_s && last_lane_s) begin
                    state_d = (remaining_q != '0) ? FETCH : FINISH;
                end else if (xfer_s) begin
                    advance_s = 1'b1;
                end else begin
                    state_d = SEND;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_rd_en_d  = (state_d == FETCH);
        mem_addr_d   = mem_rd_en_d ? addr_d : mem_addr_q;
        byte_valid_d = (state_d == SEND);
        busy_d       = ((state_q == IDLE) && bus.start) ||
                       (state_d == FETCH) || (state_d == WAIT) || (state_d == SEND);
        // A zero-length request leaves busy set through FINISH, so its done lands one cycle later
        done_d       = ((state_q == SEND) && (state_d == FINISH)) ||
                       ((state_q == FINISH) && busy_q);
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    result_stream_reader_lane_serializer u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_s),
        .word_i      (bus.mem_data_in),
        .advance_i   (advance_s),
        .byte_o      (byte_s),
        .last_lane_o (last_lane_s)
    );

    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.byte_out   = byte_s;
    assign bus.byte_valid = byte_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_result_stream_reader.sv
// Scoreboard bench for result_stream_reader: a memory model answers reads, and
// expected addresses/bytes queued at each start are compared as the DUT emits them.
module tb_result_stream_reader;
    import result_stream_reader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    result_stream_reader_if bus ();

    result_stream_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_t mem [512];

    // Memory model: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_data_in <= mem[bus.mem_addr];
    end

    int n_chk = 0;
    int n_err = 0;
    int exp_addr_q [$];
    int exp_byte_q [$];
    int n_rd = 0, n_done = 0, n_busy = 0, n_valid = 0;
    int done_cyc = 0, valid_rise_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int base, input int cnt);
        for (int w = 0; w < cnt; w++) begin
            int a;
            a = (base + w) % 512;
            exp_addr_q.push_back(a);
            for (int l = 0; l < LANES; l++) exp_byte_q.push_back(int'(mem[a][l]));
        end
    endtask

    task automatic monitor();
        forever begin
            int e;
            @(negedge clk);
            if (bus.mem_rd_en === 1'b1) begin
                n_rd++;
                e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF;
                check_eq("rd_addr", 32'(bus.mem_addr), e);
            end
            if (bus.byte_valid === 1'b1) begin
                if (!prev_valid) valid_rise_cyc = cyc;
                n_valid++;
                e = (exp_byte_q.size() > 0) ? exp_byte_q[0] : 32'hFFFF;
                check_eq("byte_out", 32'(bus.byte_out), e);
                if (bus.byte_ready && exp_byte_q.size() > 0) void'(exp_byte_q.pop_front());
            end
            prev_valid = (bus.byte_valid === 1'b1);
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.busy === 1'b1) n_busy++;
        end
    endtask

    task automatic do_start(input int base, input int cnt, output int t1);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = ADDR_W'(cnt);
        @(posedge clk); #1;
        bus.start = 1'b0;
        t1 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_within_budget", 32'(k < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_en"},  32'(bus.mem_rd_en),  32'd0);
        check_eq({tag, "_addr"},   32'(bus.mem_addr),   32'd0);
        check_eq({tag, "_byte"},   32'(bus.byte_out),   32'd0);
        check_eq({tag, "_valid"},  32'(bus.byte_valid), 32'd0);
        check_eq({tag, "_busy"},   32'(bus.busy),       32'd0);
        check_eq({tag, "_done"},   32'(bus.done),       32'd0);
    endtask

    initial begin
        int t1, rd0, done0, busy0, val0;
        for (int i = 0; i < 512; i++) mem[i] = word_t'($urandom);
        mem[5] = {8'h44, 8'h33, 8'h22, 8'h11};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        fork monitor(); join_none

        // Single word at address 5
        rd0 = n_rd; done0 = n_done; busy0 = n_busy;
        push_exp(5, 1);
        do_start(5, 1, t1);
        wait_done(40);
        check_eq("single_rd_count", 32'(n_rd - rd0), 32'd1);
        check_eq("single_first_valid", 32'(valid_rise_cyc), 32'(t1 + 2));
        check_eq("single_done_cyc", 32'(done_cyc), 32'(t1 + 6));
        check_eq("single_busy_cycles", 32'(n_busy - busy0), 32'd6);
        check_eq("single_done_count", 32'(n_done - done0), 32'd1);
        check_eq("single_bytes_left", 32'(exp_byte_q.size()), 32'd0);

        // Three words wrapping past the top of memory
        rd0 = n_rd; done0 = n_done; busy0 = n_busy; val0 = n_valid;
        push_exp(510, 3);
        do_start(510, 3, t1);
        wait_done(80);
        check_eq("wrap_rd_count", 32'(n_rd - rd0), 32'd3);
        check_eq("wrap_byte_count", 32'(n_valid - val0), 32'd12);
        check_eq("wrap_done_cyc", 32'(done_cyc), 32'(t1 + 18));
        check_eq("wrap_busy_cycles", 32'(n_busy - busy0), 32'd18);
        check_eq("wrap_done_count", 32'(n_done - done0), 32'd1);
        check_eq("wrap_left", 32'(exp_byte_q.size() + exp_addr_q.size()), 32'd0);

        // Backpressure: ready low for three cycles while lane 1 is shown
        rd0 = n_rd; done0 = n_done;
        push_exp(5, 1);
        do_start(5, 1, t1);
        repeat (3) @(posedge clk);
        #1 bus.byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.byte_ready = 1'b1;
        wait_done(40);
        check_eq("bp_rd_count", 32'(n_rd - rd0), 32'd1);
        check_eq("bp_done_cyc", 32'(done_cyc), 32'(t1 + 9));
        check_eq("bp_done_count", 32'(n_done - done0), 32'd1);
        check_eq("bp_bytes_left", 32'(exp_byte_q.size()), 32'd0);

        // Zero-length request
        rd0 = n_rd; done0 = n_done; busy0 = n_busy; val0 = n_valid;
        do_start(33, 0, t1);
        wait_done(20);
        check_eq("zero_rd_count", 32'(n_rd - rd0), 32'd0);
        check_eq("zero_valid_count", 32'(n_valid - val0), 32'd0);
        check_eq("zero_done_cyc", 32'(done_cyc), 32'(t1 + 1));
        check_eq("zero_busy_cycles", 32'(n_busy - busy0), 32'd1);
        check_eq("zero_done_count", 32'(n_done - done0), 32'd1);

        // Second start while busy is ignored
        rd0 = n_rd; done0 = n_done;
        push_exp(20, 2);
        do_start(20, 2, t1);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.base_addr = ADDR_W'(100); bus.word_count = ADDR_W'(5);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(60);
        repeat (10) @(posedge clk);
        #1;
        check_eq("busy_start_rd_count", 32'(n_rd - rd0), 32'd2);
        check_eq("busy_start_done_cyc", 32'(done_cyc), 32'(t1 + 12));
        check_eq("busy_start_done_count", 32'(n_done - done0), 32'd1);
        check_eq("busy_start_left", 32'(exp_byte_q.size() + exp_addr_q.size()), 32'd0);

        // Reset during SEND of word 2 of 3
        push_exp(40, 3);
        do_start(40, 3, t1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        exp_addr_q.delete();
        exp_byte_q.delete();
        rd0 = n_rd; done0 = n_done;
        repeat (10) @(posedge clk);
        #1;
        check_eq("midreset_no_done", 32'(n_done - done0), 32'd0);
        check_eq("midreset_no_read", 32'(n_rd - rd0), 32'd0);

        // Fresh request after the abandoned one
        rd0 = n_rd; done0 = n_done;
        push_exp(7, 1);
        do_start(7, 1, t1);
        wait_done(40);
        check_eq("after_reset_rd_count", 32'(n_rd - rd0), 32'd1);
        check_eq("after_reset_done_cyc", 32'(done_cyc), 32'(t1 + 6));
        check_eq("after_reset_bytes_left", 32'(exp_byte_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/result_stream_reader.md
Name: result_stream_reader

Overview:
- Read-back end of the convolution result path. The datapath's shift register packs four 8-bit MAC results into one memory word and writes it at the z address.
- This block reads those 4-lane words back from the same word-addressed memory, starting at a base address. It unpacks each word and streams the bytes out one per handshake.
- Sits beside the memory, after the convolution done signal. Used for result dump and check-out.

Parameters:
- ADDR_W, 9, memory word address width.
- DATA_W, 8, lane (byte) width.
- LANES, 4, lanes per memory word.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, captured on accepted start.
- word_count  in  ADDR_W  number of words to read, captured on accepted start.
- mem_rd_en  out  1  read strobe to memory.
- mem_addr  out  ADDR_W  read word address.
- mem_data_in  in  LANES x DATA_W  read data, lane 0..3, valid the cycle after the mem_rd_en cycle.
- byte_out  out  DATA_W  streamed byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  consumer accepts byte_out.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state to IDLE.
  - mem_rd_en, byte_valid, busy, done all 0.
  - mem_addr, byte_out, counters and word register 0.
  - Reset mid-transfer abandons the transfer; no done pulse is produced.
- States: IDLE, FETCH, WAIT, SEND, FINISH.
- IDLE:
  - start=1 latches base_addr into addr_q and word_count into remaining_q.
  - If word_count==0, go to FINISH; otherwise go to FETCH.
  - busy goes to 1 on the next cycle.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=addr_q, go to WAIT.
- WAIT (1 cycle):
  - mem_data_in is captured into word_q[0:3].
  - lane_q is set to 0.
  - addr_q increments modulo 2^ADDR_W, so 511 wraps to 0.
  - remaining_q decrements.
  - Go to SEND.
- SEND:
  - byte_valid=1 and byte_out=word_q[lane_q]. Lane 0 goes first and matches shift-register fill order.
  - A byte transfers when byte_valid && byte_ready at the edge.
  - While byte_ready=0, byte_out and byte_valid stay stable.
  - After a transfer of lane 3: go to FETCH if remaining_q!=0, else FINISH. Otherwise lane_q increments.
- FINISH (1 cycle): done=1, busy=0, byte_valid=0, return to IDLE.
- Latency with byte_ready held at 1:
  - start sampled at edge T.
  - FETCH during T+1.
  - First byte_valid during T+3.
  - Per word: 6 cycles (FETCH, WAIT, 4 SEND).
  - done pulses 1 cycle after the final transfer.
  - There is no read/send overlap.
- start while busy is ignored. start coincident with done is also ignored, because the state is FINISH, not IDLE.
- mem_rd_en=0 in every state except FETCH. mem_addr holds its last value when mem_rd_en=0.
- Total bytes emitted = LANES x word_count.

Decomposition:
- Shared package (conv_pkg, or the existing package):
  - state enum: IDLE, FETCH, WAIT, SEND, FINISH.
  - constants: ADDR_W, DATA_W, LANES.
  - lane-index width: $clog2(LANES).
- One natural sub-module: lane_serializer. It holds word_q and lane_q and provides load, advance, byte_out, and last_lane. The FSM and address/remaining counters stay in the top.

Test Plan:
- Single word: memory[5]={0x11,0x22,0x33,0x44}, start with base=5, count=1, ready=1.
  - Expect bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting T+3.
  - Expect mem_rd_en pulsed once with addr 5, done at T+7, busy high T+1..T+6.
- Multi-word with wrap: base=510, count=3.
  - Expect read addresses 510, 511, 0 and 12 bytes in lane order.
  - Expect 6-cycle word cadence, then one done pulse.
- Backpressure: count=1, byte_ready=0 for 3 cycles on lane 1.
  - Expect byte_out to hold 0x22 with byte_valid=1, no lane advance, and no extra memory read.
  - Expect done to arrive 3 cycles later than the ready=1 case.
- Zero count: start with count=0.
  - Expect no mem_rd_en and no byte_valid.
  - Expect done pulse at T+2, busy high only during FINISH-entry cycle T+1.
- Start while busy: second start mid-SEND with different base.
  - Expect it ignored: addresses and byte stream unchanged, exactly one done.
- Reset mid-operation: rst=1 during SEND of word 2 of 3.
  - Expect all outputs 0 the next cycle, no done.
  - A new start then works normally from IDLE.
